mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Two-port arbiter and sequencer for the CPU's single-port main memory. Port A is the CPU control-unit path (fetch, ld, st). Port B is the loader/debug path. The block grants one port at a time, drives the memory address, data and strobes through a fixed multi-cycle access sequence, and returns read data with a one-cycle ack pulse. It replaces the ad-hoc mari/mem_read/mem_write strobing with a single owner of the memory bus.

Parameters:
ADDR_W, 9, memory word-address width (512 words)
DATA_W, 32, data word width
MEM_LAT, 1, cycles from the mem_read cycle to mem_rdata valid; legal range 1..15

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
a_req  in  1  port A request; held with fields stable until a_ack
a_we  in  1  port A: 1 = write, 0 = read
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  port A completion pulse, 1 cycle
a_rdata  out  DATA_W  port A read data, valid while a_ack=1 and held until the next A read completes
b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  port B, same semantics as port A
b_ack  out  1  port B completion pulse
b_rdata  out  DATA_W  port B read data
mem_addr  out  ADDR_W  registered memory address
mem_wdata  out  DATA_W  registered memory write data
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data
busy  out  1  1 in every state except IDLE
owner_b  out  1  0 = A owns the bus, 1 = B owns it; meaningful while busy=1

Behaviour:
- Clock is clock. Reset is reset, synchronous and active-high.
- Reset values: all outputs 0. State = IDLE. last_grant = B, so A wins the first tie. Wait counter = 0.
- Reset mid-operation: the next edge returns to IDLE with all strobes and acks 0. The in-flight access is abandoned and no ack is issued.
- States: IDLE, ADDR, ACCESS, WAIT, DONE.
- IDLE: samples a_req and b_req.
  - Only one request asserted: grant that port.
  - Both asserted: grant the port that is not last_grant (round-robin).
  - On a grant: latch owner, we, addr and wdata. Update last_grant. Go to ADDR.
  - Neither asserted: stay in IDLE.
- ADDR (1 cycle): mem_addr and mem_wdata drive the latched values; strobes are 0. Next state is ACCESS.
- ACCESS (1 cycle):
  - Write: mem_write=1. Next state is DONE.
  - Read: mem_read=1. Load the counter with MEM_LAT. Next state is WAIT.
- WAIT: the counter decrements each cycle. In the cycle where the counter equals 1, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE (1 cycle): the owner's ack = 1. Next state is IDLE.
- mem_addr and mem_wdata hold their values after the access. No other output changes except as stated above.
- Latency, counting T as the IDLE cycle in which the request is sampled:
  - Read: ack at T+3+MEM_LAT (T+4 when MEM_LAT=1).
  - Write: ack at T+3.
  - Minimum spacing between back-to-back grants is ack cycle + 1 (the IDLE cycle).
- Exactly one of mem_read and mem_write is high, and only in ACCESS. Both are never high together.
- The non-owner's ack stays 0. The non-owner's rdata register is unchanged.
- A request that drops after grant still completes and still pulses ack; the requester ignores it. Changes to addr, wdata or we after grant have no effect.
- A requester that holds req high through its ack is treated as a new request in the following IDLE cycle. The round-robin rule still applies, so a continuously requesting port cannot starve the other.
- Request inputs are only sampled in IDLE. Requests arriving during busy wait; none are lost while req is held.

Test Plan:
1. MEM_LAT=1, memory preloaded [0x010]=0xDEADBEEF. Pulse-hold a_req with a_we=0, a_addr=0x010 → mem_read high exactly 1 cycle at T+2, a_ack at T+4, a_rdata=0xDEADBEEF, b_ack stays 0.
2. b_req with b_we=1, b_addr=0x1FF, b_wdata=0x12345678 → mem_write high at T+2 with mem_addr=0x1FF and mem_wdata=0x12345678, b_ack at T+3. A later A read of 0x1FF returns 0x12345678.
3. a_req and b_req both held high for 4 transactions from reset → grant order A, B, A, B with owner_b toggling. Each grant follows the previous ack by exactly 1 cycle.
4. MEM_LAT=3, A read of 0x005 with memory data valid 3 cycles after mem_read → a_ack at T+6 with the correct data; mem_read never asserted more than 1 cycle.
5. Assert reset during WAIT of an A read → next cycle busy=0, all strobes 0, no a_ack. A fresh A request completes normally with standard latency.
6. Port A changes a_addr from 0x010 to 0x020 and drops a_req one cycle after grant → access still targets 0x010, a_ack still pulses once, then the block returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter and access sequencer for single-port main memory
//
// Grants port A (CPU control path) or port B (loader/debug path) one at a time and
// walks the granted access through IDLE -> ADDR -> ACCESS -> (WAIT) -> DONE.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request, held with stable fields until a_ack
//   a_ack, a_rdata          port A one-cycle completion pulse and held read data
//   b_req/b_we/b_addr/b_wdata  port B request, same semantics as port A
//   b_ack, b_rdata          port B completion pulse and held read data
//   mem_addr, mem_wdata     registered memory address and write data
//   mem_read, mem_write     memory strobes, high only in the ACCESS cycle
//   mem_rdata               memory read data, valid MEM_LAT cycles after mem_read
//   busy                    high in every state except IDLE
//   owner_b                 0 = A owns the bus, 1 = B owns it (meaningful while busy)

module mem_port_arbiter #(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner_b
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t     state, state_nxt;
   logic       owner_q;
   logic       we_q;
   logic       last_b_q;   // 1 = port B was granted last
   logic [3:0] cnt_q;
   logic       grant;
   logic       grant_b;

   // Next-state and grant decision. On a tie the port that did not win last time
   // is chosen, so a port that keeps its request up cannot starve the other.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_b   = 1'b0;
      case (state)
         IDLE: begin
            if (a_req && b_req) begin
               grant   = 1'b1;
               grant_b = ~last_b_q;
            end else if (a_req) begin
               grant   = 1'b1;
            end else if (b_req) begin
               grant   = 1'b1;
               grant_b = 1'b1;
            end
            if (grant) state_nxt = ADDR;
         end
         ADDR:    state_nxt = ACCESS;
         ACCESS:  state_nxt = we_q ? DONE : WAIT;
         WAIT:    if (cnt_q <= 4'd1) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes and acks decode straight from registered state, so a reset edge
   // clears them all in the following cycle.
   assign mem_read  = (state == ACCESS) && !we_q;
   assign mem_write = (state == ACCESS) &&  we_q;
   assign a_ack     = (state == DONE) && !owner_q;
   assign b_ack     = (state == DONE) &&  owner_q;
   assign busy      = (state != IDLE);
   assign owner_b   = owner_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         last_b_q  <= 1'b1;
         cnt_q     <= 4'd0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_rdata   <= '0;
         b_rdata   <= '0;
      end else begin
         state <= state_nxt;

         // mem_addr/mem_wdata double as the latched request fields; they are
         // loaded only on a grant and otherwise hold.
         if (grant) begin
            owner_q   <= grant_b;
            last_b_q  <= grant_b;
            we_q      <= grant_b ? b_we    : a_we;
            mem_addr  <= grant_b ? b_addr  : a_addr;
            mem_wdata <= grant_b ? b_wdata : a_wdata;
         end

         if (state == ACCESS && !we_q) begin
            cnt_q <= 4'(MEM_LAT);
         end else if (state == WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
         end

         // The counter reaching 1 marks the cycle in which mem_rdata is valid.
         if (state == WAIT && cnt_q == 4'd1) begin
            if (owner_q) b_rdata <= mem_rdata;
            else         a_rdata <= mem_rdata;
         end
      end
   end

endmodule
